// File: rtl/ui_text_pkg.sv
// Shared definitions for the UI ASCII-stream interface.
package ui_text_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } sender_state_e;

endpackage

// File: rtl/ui_text_trim_len.sv
// Trimmed length of a packed string: 1 + index of the last non-pad character,
// or 1 when the whole string is padding so the sink still receives one blank.
module ui_text_trim_len
  import ui_text_pkg::*;
#(
  parameter int         MAX_CHARS = 16,
  parameter logic [7:0] PAD_CHAR  = ASCII_SPACE
) (
  input  logic [8*MAX_CHARS-1:0]         string_i,
  output logic [$clog2(MAX_CHARS+1)-1:0] len_o
);
  localparam int LW = $clog2(MAX_CHARS + 1);

  // Later characters override earlier ones, so the last non-pad wins.
  always_comb begin
    len_o = LW'(1);
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (string_i[8*(MAX_CHARS-1-i) +: 8] != PAD_CHAR) begin
        len_o = LW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/ui_text_sender.sv
// Streams a latched, pad-trimmed string byte-by-byte to the LCD text scroller,
// framed by ascii_data_ready and followed by a fixed ready-low gap.
//
//   state | meaning
//   IDLE  | waiting for start; done pulses here after a message
//   SCAN  | trim length computed, first character launched
//   SEND  | remaining characters streamed, one per cycle
//   GAP   | ready held low for GAP_CYCLES so the sink closes its frame
module ui_text_sender
  import ui_text_pkg::*;
#(
  parameter int         MAX_CHARS  = 16,
  parameter int         GAP_CYCLES = 4,
  parameter logic [7:0] PAD_CHAR   = ASCII_SPACE
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [8*MAX_CHARS-1:0]         string_in,
  input  logic                           start,
  input  logic                           abort,
  output logic [7:0]                     ascii_data,
  output logic                           ascii_data_ready,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MAX_CHARS+1)-1:0] msg_len
);
  localparam int LW = $clog2(MAX_CHARS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int SW = 8 * MAX_CHARS;

  sender_state_e state_q, state_d;
  logic [SW-1:0] hold_q, hold_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] msg_len_q, msg_len_d;
  logic [LW-1:0] trim_len;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  ui_text_trim_len #(
    .MAX_CHARS(MAX_CHARS),
    .PAD_CHAR (PAD_CHAR)
  ) u_trim (
    .string_i(hold_q),
    .len_o   (trim_len)
  );

  // The holding register shifts left as characters go out, so the next
  // character is always in the top byte.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    msg_len_d = msg_len_q;
    gap_d     = gap_q;
    data_d    = data_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hold_d  = string_in;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        msg_len_d = trim_len;
        gap_d     = GW'(GAP_CYCLES - 1);
        if (abort) begin
          state_d = ST_GAP;
        end else begin
          data_d  = hold_q[SW-1 -: 8];
          hold_d  = hold_q << 8;
          ready_d = 1'b1;
          idx_d   = LW'(1);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        gap_d = GW'(GAP_CYCLES - 1);
        if (abort || (idx_q == msg_len_q)) begin
          ready_d = 1'b0;
          data_d  = PAD_CHAR;
          state_d = ST_GAP;
        end else begin
          data_d = hold_q[SW-1 -: 8];
          hold_d = hold_q << 8;
          idx_d  = idx_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      idx_q     <= '0;
      msg_len_q <= '0;
      gap_q     <= '0;
      data_q    <= PAD_CHAR;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      msg_len_q <= msg_len_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ascii_data       = data_q;
  assign ascii_data_ready = ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign msg_len          = msg_len_q;

endmodule

// File: tb/tb_ui_text_sender.sv
// Scoreboard bench for ui_text_sender: stimulus queues expected characters and
// frame lengths, a negedge monitor rebuilds frames and compares.
module tb_ui_text_sender;

  localparam int MAX_CHARS  = 16;
  localparam int GAP_CYCLES = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [127:0] string_in = '0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   ascii_data;
  logic         ascii_data_ready;
  logic         busy;
  logic         done;
  logic [4:0]   msg_len;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_chars[$];
  int         exp_flen[$];
  int         exp_mlen[$];

  int   cur_len = 0;
  int   low_cnt = 0;
  logic in_gap = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_done = 1'b0;

  ui_text_sender #(
    .MAX_CHARS (MAX_CHARS),
    .GAP_CYCLES(GAP_CYCLES),
    .PAD_CHAR  (8'h20)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .string_in       (string_in),
    .start           (start),
    .abort           (abort),
    .ascii_data      (ascii_data),
    .ascii_data_ready(ascii_data_ready),
    .busy            (busy),
    .done            (done),
    .msg_len         (msg_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input string s);
    logic [127:0] v;
    v = {16{8'h20}};
    for (int i = 0; i < s.len() && i < 16; i++) v[127-8*i -: 8] = s[i];
    return v;
  endfunction

  task automatic push_exp(input string e, input int flen, input int mlen);
    for (int i = 0; i < flen; i++) exp_chars.push_back(e[i]);
    exp_flen.push_back(flen);
    exp_mlen.push_back(mlen);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=0 expected 1", tag);
    end
  endtask

  // Monitor: rebuilds frames, checks gap length and done behaviour.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ready = 1'b0;
      prev_done  = 1'b0;
      cur_len    = 0;
      low_cnt    = 0;
      in_gap     = 1'b0;
    end else begin
      if (ascii_data_ready) begin
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        if (exp_chars.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char: got %0h expected none", ascii_data);
        end else begin
          check("char", {24'd0, ascii_data}, {24'd0, exp_chars.pop_front()});
        end
        cur_len++;
      end else if (prev_ready) begin
        if (exp_flen.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got len %0d expected none", cur_len);
        end else begin
          check("frame_len", cur_len, exp_flen.pop_front());
          check("msg_len", {27'd0, msg_len}, exp_mlen.pop_front());
        end
        cur_len = 0;
        low_cnt = 1;
        in_gap  = 1'b1;
      end else if (in_gap && !done) begin
        low_cnt++;
      end
      if (done) begin
        check("done_single", {31'd0, prev_done}, 32'd0);
        check("done_no_ready", {31'd0, ascii_data_ready}, 32'd0);
        check("done_not_busy", {31'd0, busy}, 32'd0);
        if (in_gap) check("gap_len", low_cnt, GAP_CYCLES);
        in_gap = 1'b0;
      end
      prev_ready = ascii_data_ready;
      prev_done  = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_data", {24'd0, ascii_data}, 32'h20);
    check("rst_ready", {31'd0, ascii_data_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_msg_len", {27'd0, msg_len}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: HELLO with trailing spaces, latency check
    string_in = pack("HELLO");
    start = 1'b1;
    push_exp("HELLO", 5, 5);
    @(negedge clk);
    start = 1'b0;
    check("t1_busy_after_start", {31'd0, busy}, 32'd1);
    check("t1_ready_scan", {31'd0, ascii_data_ready}, 32'd0);
    @(negedge clk);
    check("t1_ready_first", {31'd0, ascii_data_ready}, 32'd1);
    wait_done("t1");
    @(negedge clk);

    // 2: full-width string
    string_in = pack("0123456789ABCDEF");
    start = 1'b1;
    push_exp("0123456789ABCDEF", 16, 16);
    @(negedge clk);
    start = 1'b0;
    wait_done("t2");
    @(negedge clk);

    // 3: all-pad string sends a single blank
    string_in = pack("");
    start = 1'b1;
    push_exp(" ", 1, 1);
    @(negedge clk);
    start = 1'b0;
    wait_done("t3");
    @(negedge clk);

    // 4: start held through SEND (ignored) and into the done cycle (accepted)
    string_in = pack("WORLD!");
    start = 1'b1;
    push_exp("WORLD!", 6, 6);
    push_exp("XYZ", 3, 3);
    @(negedge clk);
    string_in = pack("XYZ");
    wait_done("t4a");
    @(negedge clk);
    start = 1'b0;
    check("t4_second_accepted", {31'd0, busy}, 32'd1);
    wait_done("t4b");
    @(negedge clk);

    // 5: abort on third SEND cycle
    string_in = pack("HELLO");
    start = 1'b1;
    push_exp("HEL", 3, 5);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("t5");
    @(negedge clk);

    // 5b: start and abort together in IDLE, start wins
    string_in = pack("OK");
    start = 1'b1;
    abort = 1'b1;
    push_exp("OK", 2, 2);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    wait_done("t5b");
    @(negedge clk);

    // 6: asynchronous reset mid-message
    string_in = pack("HELLO");
    start = 1'b1;
    push_exp("HELLO", 5, 5);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_ready", {31'd0, ascii_data_ready}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_data", {24'd0, ascii_data}, 32'h20);
    check("t6_msg_len", {27'd0, msg_len}, 32'd0);
    exp_chars.delete();
    exp_flen.delete();
    exp_mlen.delete();
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    string_in = pack("BYE");
    start = 1'b1;
    push_exp("BYE", 3, 3);
    @(negedge clk);
    start = 1'b0;
    wait_done("t6");
    repeat (3) @(negedge clk);

    check("chars_drained", exp_chars.size(), 32'd0);
    check("frames_drained", exp_flen.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
